struct_dflop_timer: RTL

- Loadable down-counting timer with a valid/ready load handshake. It is the consumer-side counterpart of the loadable up-counter flop.
- A value is loaded, counted down to zero under `enable`, and expiry is signalled by a one-cycle `done` pulse. Optional auto-reload makes it a periodic tick source.
- Sits in the pyrope struct/flop test family and is used as a countdown/timeout primitive feeding control FSMs.

---
 rtl/struct_timer_pkg.sv | 19 +
 rtl/struct_dflop_timer.sv | 115 +++++++++++
 2 files changed

// File: rtl/struct_timer_pkg.sv
// Shared types for the loadable down-counting timer: FSM state encoding,
// the default counter width and the bundle captured on a load transfer.
package struct_timer_pkg;

    localparam int TIMER_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    // Everything that travels with an accepted load request.
    typedef struct packed {
        logic [TIMER_WIDTH-1:0] value;
        logic                   auto_reload;
    } timer_cfg_t;

endpackage : struct_timer_pkg

// File: rtl/struct_dflop_timer.sv
// Loadable down-counting timer with a valid/ready load port, a one-cycle
// expiry pulse and optional auto-reload for periodic ticks. `out` exposes
// the value the counter will hold after the next edge.
module struct_dflop_timer
    import struct_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             enable,
    input  logic             cancel,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             arm_q, arm_d;

    timer_cfg_t       load_cfg;
    logic             load_accept;
    logic             load_nonzero;

    // A load can only land while no countdown is in progress.
    assign load_ready   = !reset && (state_q != RUN);
    assign load_accept  = load_valid && load_ready;
    assign load_cfg     = '{value: a, auto_reload: auto_reload};
    assign load_nonzero = (load_cfg.value != '0);

    // Next-state and counter logic; reset is folded in so `out` reads 0 during reset.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        arm_d    = arm_q;
        if (reset) begin
            state_d  = IDLE;
            count_d  = '0;
            reload_d = '0;
            arm_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // cancel has nothing to abort here and is ignored
                    if (load_accept) begin
                        count_d  = load_cfg.value;
                        reload_d = load_cfg.value;
                        arm_d    = load_cfg.auto_reload;
                        state_d  = load_nonzero ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state_d = IDLE;
                        count_d = '0;
                        arm_d   = 1'b0;
                    end else if (enable && (count_q != '0)) begin
                        count_d = count_q - WIDTH'(1);
                        if (count_q == WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    count_d = '0;
                    // an explicit load takes precedence over auto-reload
                    if (load_accept) begin
                        count_d  = load_cfg.value;
                        reload_d = load_cfg.value;
                        arm_d    = load_cfg.auto_reload;
                        state_d  = load_nonzero ? RUN : DONE;
                    end else if (arm_q && (reload_q != '0)) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                    arm_d   = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            arm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            arm_q    <= arm_d;
        end
    end

    // Status decoded straight from the state register, silenced while in reset.
    assign out  = count_d;
    assign busy = !reset && (state_q == RUN);
    assign done = !reset && (state_q == DONE);

endmodule : struct_dflop_timer
